bcd_share_arbiter: RTL
======================

BCD_SHARE_ARBITER -- requirements
Module: bcd_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the converter; legal range 2..8.
REQ-002 Parameter IDW, default $clog2(N_REQ), width of the requester-id output.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  level request, one bit per requester.
REQ-006 bin_in  input  4*N_REQ  binary operand; requester i uses bits [4i+3:4i].
REQ-007 gnt  output  N_REQ  one-hot, one-cycle grant pulse.
REQ-008 bcd_out  output  8  result: [7:4] tens digit, [3:0] units digit.
REQ-009 out_valid  output  1  bcd_out and out_id valid.
REQ-010 out_id  output  IDW  index of the requester owning the result.
REQ-011 out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, CONV, RESP; one transaction in flight at a time.
REQ-014 IDLE: if req != 0, arbitrate, pulse gnt[w] for one cycle, capture bin_in slice w and w, then go to CONV; else stay.
REQ-015 Round-robin arbitration: search starts at last-granted index + 1 modulo N_REQ; the first set req bit wins.
REQ-016 CONV: register bcd = {tens, units} of the captured value, where tens = 1 if value >= 10 else 0 and units = value mod 10; go to RESP.
REQ-017 RESP: out_valid = 1; hold bcd_out and out_id stable until out_ready = 1; on acceptance, update last-granted to w and go to IDLE.
REQ-018 Latency: grant in cycle T; out_valid rises in cycle T+2; earliest next grant is the cycle after acceptance.
REQ-019 A requester holds req and its bin_in stable until it sees its gnt, and deasserts req the cycle after gnt unless it has a new operand.
REQ-020 Changes to req or bin_in in CONV or RESP have no effect on the in-flight transaction.
REQ-021 Inputs 0..15 are all legal; 15 -> 8'h15, 9 -> 8'h09, 10 -> 8'h10.
REQ-022 With no requests, the FSM stays in IDLE and gnt stays 0.

Reset
REQ-023 Asserting rst_n low forces IDLE immediately, including mid-transaction; the in-flight transaction is dropped without out_valid.
REQ-024 Reset values: gnt = 0, bcd_out = 8'h00, out_valid = 0, out_id = 0, busy = 0, last-granted = N_REQ-1, so requester 0 has first priority.

Configuration
REQ-025 Macro BCD_ARB_FIXED_PRIO_EN:
- Defined: fixed priority; the lowest set req index always wins and last-granted is unused.
- Undefined: round robin as in REQ-015.
- All other behaviour is identical in both builds.

Structure
REQ-026 Shared package bcd_arb_pkg holds the FSM state enum (IDLE, CONV, RESP) and the BCD digit-width constant (4).
REQ-027 One sub-module, nibble_bcd_lut: a combinational 4-bit -> 8-bit BCD converter instantiated once and fed by the captured operand.

Verification
REQ-028 Single request: req = 4'b0001, bin_in[3:0] = 4'd13, out_ready = 1 -> gnt = 0001 at T, out_valid at T+2 with bcd_out = 8'h13, out_id = 0.
REQ-029 Round robin: req = 4'b1111 held, operands 3/7/10/15 -> grants in order 0,1,2,3,0; results 8'h03, 8'h07, 8'h10, 8'h15.
REQ-030 Backpressure: out_ready = 0 for 5 cycles in RESP -> out_valid, bcd_out and out_id stay stable, no new gnt; acceptance on the 6th cycle, then the next grant one cycle later.
REQ-031 Reset mid-operation: rst_n low during CONV -> outputs at reset values at once; after release, pending req = 4'b0100 is granted first with gnt = 0100.
REQ-032 Fixed priority (BCD_ARB_FIXED_PRIO_EN defined): req = 4'b0110 held across three transactions -> gnt = 0010 every time.
REQ-033 Exhaustive operand sweep 0..15 on requester 2 -> bcd_out matches {value/10, value%10} and out_id = 2 for every value.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_arb_pkg
// Purpose  : Shared types and constants for the BCD share arbiter:
//            the arbiter FSM state encoding and the BCD digit width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_arb_pkg;

  // Width of one BCD digit (and of one binary operand nibble).
  localparam int c_BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage : bcd_arb_pkg
`default_nettype wire

// File: rtl/nibble_bcd_lut.sv
`default_nettype none
// ============================================================================
// Module   : nibble_bcd_lut
// Purpose  : Combinational 4-bit binary to two-digit BCD converter.
//            A nibble never exceeds 15, so the tens digit is 0 or 1.
// Ports    : i_bin  - binary operand 0..15
//            o_bcd  - {tens, units} BCD result
// Revision : 1.0 - initial release
// ============================================================================
module nibble_bcd_lut
  import bcd_arb_pkg::*;
(
  input  logic [c_BCD_DIGIT_W-1:0]   i_bin,
  output logic [2*c_BCD_DIGIT_W-1:0] o_bcd
);

  logic                     w_ge10;
  logic [c_BCD_DIGIT_W-1:0] w_units;

  assign w_ge10  = (i_bin >= 4'd10);
  assign w_units = w_ge10 ? (i_bin - 4'd10) : i_bin;
  assign o_bcd   = {{(c_BCD_DIGIT_W-1){1'b0}}, w_ge10, w_units};

endmodule : nibble_bcd_lut
`default_nettype wire

// File: rtl/bcd_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_share_arbiter
// Purpose  : Shares one nibble-to-BCD converter among N_REQ requesters.
//            IDLE arbitrates and issues a one-cycle grant, CONV registers
//            the conversion, RESP presents the result until accepted.
//            Round-robin arbitration by default; defining the macro
//            BCD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index).
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            req          - level request per requester
//            bin_in       - operands, requester i on [4i+3:4i]
//            gnt          - one-hot grant pulse
//            bcd_out      - {tens, units} result
//            out_valid    - result valid
//            out_id       - requester owning the result
//            out_ready    - consumer accepts result
//            busy         - FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module bcd_share_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   bin_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [7:0]           bcd_out,
  output logic                 out_valid,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready,
  output logic                 busy
);

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  logic                     w_take;
  logic [IDW-1:0]           w_win;
  logic [IDW-1:0]           w_idx;
  logic [c_BCD_DIGIT_W-1:0] r_opnd;
  logic [IDW-1:0]           r_id;
  logic [7:0]               r_bcd;
  logic [7:0]               w_lut_bcd;
`ifndef BCD_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]           r_last;
`endif

  // --------------------------------------------------------------------------
  // Winner selection. Both loops run from the lowest-priority candidate to
  // the highest so the last match seen is the winner (no found-flag needed).
  // --------------------------------------------------------------------------
  always_comb begin
    w_win = '0;
    w_idx = '0;
`ifdef BCD_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = IDW'(i);
      if (req[w_idx]) w_win = w_idx;
    end
`else
    // Search order is r_last+1, r_last+2, ... so k=1 has highest priority.
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last) + k) % N_REQ);
      if (req[w_idx]) w_win = w_idx;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Next-state and grant logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_take      = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV:    w_state_nxt = RESP;
      RESP:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant is combinational so it lands in the same cycle the operand is
  // captured; it is masked while reset is held so gnt reads 0 in reset.
  assign gnt = (w_take && rst_n) ? (N_REQ'(1) << w_win) : '0;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opnd  <= '0;
      r_id    <= '0;
      r_bcd   <= '0;
`ifndef BCD_ARB_FIXED_PRIO_EN
      r_last  <= IDW'(N_REQ - 1);
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        // Operand slice base is w_win * 4 (digit width).
        r_opnd <= bin_in[{w_win, 2'b00} +: c_BCD_DIGIT_W];
        r_id   <= w_win;
      end
      if (r_state == CONV) r_bcd <= w_lut_bcd;
`ifndef BCD_ARB_FIXED_PRIO_EN
      if ((r_state == RESP) && out_ready) r_last <= r_id;
`endif
    end
  end

  nibble_bcd_lut u_lut (
    .i_bin (r_opnd),
    .o_bcd (w_lut_bcd)
  );

  assign bcd_out   = r_bcd;
  assign out_id    = r_id;
  assign out_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);

endmodule : bcd_share_arbiter
`default_nettype wire
